uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8: data bits per frame.
REQ-002 Parameter SB_TICK, default 16: oversampling ticks in the stop bit.
REQ-003 Parameter DVSR, default 326: clk cycles per oversampling tick (16 ticks per bit).
REQ-004 Parameter DVSR_BIT, default 9: width of the baud counter.
REQ-005 Parameter FIFO_W, default 2: FIFO address width, giving a depth of 2^FIFO_W.
REQ-006 Port clk, input, 1: single clock for all logic.
REQ-007 Port rst, input, 1: reset, asynchronous and active-low.
REQ-008 Port rx, input, 1: serial line, asynchronous to clk, idle high.
REQ-009 Port rd_uart, input, 1: pop request for the FIFO head.
REQ-010 Port r_data, output, DBIT: FIFO head byte (first-word fall-through).
REQ-011 Port rx_empty, output, 1: FIFO empty.
REQ-012 Port rx_full, output, 1: FIFO full.
REQ-013 Port frame_err, output, 1: one-cycle pulse when a frame's stop bit samples 0.
REQ-014 Port overrun, output, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-015 Port parity_err, output, 1: one-cycle pulse on a parity mismatch; tied 0 when UART_RX_PARITY_EN is undefined.

Function
REQ-016 rx shall pass through a 2-flop synchronizer before use; both flops reset to 1.
REQ-017 The baud counter shall run freely from 0 to DVSR-1 and then wrap, asserting tick for one clk at count DVSR-1.
REQ-018 The FSM shall have the states IDLE, START, DATA, PARITY and STOP, with oversample counter s (4 bits) and bit counter n.
REQ-019 IDLE: when synced rx is 0, go to START and set s=0.
REQ-020 START: on the tick where s=7, go to DATA with s=0 and n=0 if rx=0, else return to IDLE (glitch reject).
REQ-021 DATA: on the tick where s=15, shift rx into the MSB of the shift register (LSB-first frame) and set s=0; when n=DBIT-1, go to PARITY if enabled, else STOP.
REQ-022 STOP: on the tick where s=SB_TICK-1, push the byte if rx=1, else pulse frame_err and discard the byte; go to IDLE in both cases.
REQ-023 The pushed byte shall be visible on r_data, with rx_empty low, 1 clk after the stop-sample tick.
REQ-024 Push into a full FIFO: drop the byte, pulse overrun, and leave the contents unchanged.
REQ-025 rd_uart while empty: ignore the request; pointers shall not change.
REQ-026 Push and pop in the same cycle while full: both succeed, no overrun, still full.
REQ-027 Push and pop in the same cycle while empty: the push succeeds and the pop is ignored.
REQ-028 Pointers shall wrap modulo 2^FIFO_W; full and empty shall derive from an occupancy count of width FIFO_W+1.
REQ-029 A byte rejected for a framing or parity error shall never enter the FIFO.

Reset
REQ-030 Asserting rst shall set the FSM to IDLE, clear all counters, empty the FIFO, and set rx_empty=1, rx_full=0, frame_err=0, overrun=0, parity_err=0 and r_data=0.
REQ-031 Reset mid-frame shall abandon the frame; no partial byte shall ever be pushed.
REQ-032 After reset deassertion the block shall need a full new start bit; a line already low counts as a start only after passing the synchronizer.

Configuration
REQ-033 Macro UART_RX_PARITY_EN, when defined, shall enable the PARITY state: one even-parity bit after the data, sampled at s=15.
REQ-034 With UART_RX_PARITY_EN defined, a mismatch shall pulse parity_err in STOP and discard the byte, even if the stop bit is good.
REQ-035 Without UART_RX_PARITY_EN, DATA shall go directly to STOP, parity_err shall be constant 0, and no parity logic shall be synthesized.

Verification (bit period = 16*DVSR = 5216 clk)
REQ-036 Frame 0xA5 with a good stop bit -> r_data=0xA5 and rx_empty=0 one clk after the stop-sample tick; rd_uart pulse -> rx_empty=1.
REQ-037 rx low for 4 ticks, then high -> FSM back in IDLE, no push, rx_empty stays 1.
REQ-038 Frame 0x3C with stop bit 0 -> one frame_err pulse, rx_empty stays 1.
REQ-039 Bytes 0x01..0x05 with no reads (depth 4) -> overrun pulse on 0x05; reads return 0x01, 0x02, 0x03, 0x04, then rx_empty=1.
REQ-040 rst asserted mid-DATA of 0xFF, then frame 0x5A -> only 0x5A received.
REQ-041 With UART_RX_PARITY_EN: 0x07 with parity bit 0 (wrong) -> parity_err pulse, no push; 0x07 with parity bit 1 -> r_data=0x07.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop rx synchronizer, 16x oversampling FSM and a first-word
// fall-through receive FIFO. Define UART_RX_PARITY_EN to add an even-parity bit after the data.
module uart_rx #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR     = 326,
    parameter int DVSR_BIT = 9,
    parameter int FIFO_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    input  logic            rd_uart,
    output logic [DBIT-1:0] r_data,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            frame_err,
    output logic            overrun,
    output logic            parity_err
);

    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [FIFO_W:0] DEPTH_CNT = (FIFO_W + 1)'(1 << FIFO_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // ---------------- input synchronizer ----------------
    logic sync_q1;
    logic rx_sync;

    // NOTE: non-blocking assignments make each flop capture the previous stage's
    // old value, which is what turns these two statements into a shift chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            sync_q1 <= rx;
            rx_sync <= sync_q1;
        end
    end

    // ---------------- oversampling tick ----------------
    logic [DVSR_BIT-1:0] baud_cnt;
    logic                tick;

    assign tick = (baud_cnt == DVSR_BIT'(DVSR - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      baud_cnt <= '0;
        else if (tick) baud_cnt <= '0;
        else           baud_cnt <= baud_cnt + DVSR_BIT'(1);
    end

    // ---------------- receive FSM ----------------
    state_t          state;
    logic [3:0]      s;
    logic [N_W-1:0]  n;
    logic [DBIT-1:0] b;
    logic            stop_sample;
    logic            push;

    assign stop_sample = (state == STOP) && tick && (s == 4'(SB_TICK - 1));

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic parity_ok;

    // Even parity: data bits plus parity bit carry an even number of ones.
    assign parity_ok = ((^b) == par_bit);
    assign push      = stop_sample && rx_sync && parity_ok;
`else
    assign push       = stop_sample && rx_sync;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            s         <= '0;
            n         <= '0;
            b         <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s == 4'd7) begin
                            // Mid start bit: a line back high was only a glitch.
                            if (!rx_sync) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == 4'd15) begin
                            s <= '0;
                            b <= {rx_sync, b[DBIT-1:1]};
                            if (n == N_W'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                n <= n + N_W'(1);
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (s == 4'd15) begin
                            par_bit <= rx_sync;
                            s       <= '0;
                            state   <= STOP;
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (s == 4'(SB_TICK - 1)) begin
                            frame_err <= !rx_sync;
`ifdef UART_RX_PARITY_EN
                            parity_err <= !parity_ok;
`endif
                            state <= IDLE;
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- receive FIFO ----------------
    logic [DBIT-1:0]   mem [1 << FIFO_W];
    logic [FIFO_W-1:0] wr_ptr;
    logic [FIFO_W-1:0] rd_ptr;
    logic [FIFO_W:0]   count;
    logic              do_pop;
    logic              do_push;

    assign rx_empty = (count == '0);
    assign rx_full  = (count == DEPTH_CNT);
    assign do_pop   = rd_uart && !rx_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push  = push && (!rx_full || do_pop);
    assign r_data   = rx_empty ? '0 : mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; r_data is forced to 0
    // while empty, so stale contents are never visible after reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= b;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && !do_push;
            if (do_push) wr_ptr <= wr_ptr + FIFO_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + FIFO_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (FIFO_W + 1)'(1);
                2'b01:   count <= count - (FIFO_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
